// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_pkg : opcodes, FSM states and datapath select encodings for the       |
// |            multi-cycle RV32I control unit                                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [4:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
    ALU_BGEU
  } aluop_e;

  typedef enum logic [2:0] {
    REGSEL_ALU, REGSEL_IMM_U, REGSEL_GPIO_IN, REGSEL_MEM, REGSEL_PC4
  } regsel_e;

  typedef enum logic [1:0] {
    PCSEL_PC4, PCSEL_BRANCH, PCSEL_JAL, PCSEL_JALR
  } pc_sel_e;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU, CL_LUI, CL_AUIPC, CL_BRANCH, CL_JAL, CL_JALR,
    CL_LOAD, CL_STORE, CL_CSR
  } instr_class_e;

  function automatic aluop_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_decode : combinational opcode/funct classifier (class, aluop, alusrc, |
// |               legal); illegal encodings are reported as CL_NOP             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_e cls,
  output aluop_e       aluop,
  output logic         alusrc,
  output logic         legal
);

  always_comb begin
    cls    = CL_NOP;
    aluop  = ALU_NONE;
    alusrc = 1'b0;
    legal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls   = CL_ALU;
        aluop = alu_from_f3(funct3, funct7[5]);
        legal = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OPIMM: begin
        // only the shift-right immediate uses bit 30 as an operation select
        cls    = CL_ALU;
        alusrc = 1'b1;
        aluop  = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal = 1'b1;
      end
      OPC_LUI:   begin cls = CL_LUI;   aluop = ALU_ADD; alusrc = 1'b1; legal = 1'b1; end
      OPC_AUIPC: begin cls = CL_AUIPC; aluop = ALU_ADD; alusrc = 1'b1; legal = 1'b1; end
      OPC_JAL:   begin cls = CL_JAL;   aluop = ALU_ADD; alusrc = 1'b1; legal = 1'b1; end
      OPC_JALR: begin
        cls = CL_JALR; aluop = ALU_ADD; alusrc = 1'b1; legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        cls   = CL_BRANCH;
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        case (funct3)
          3'b000:  aluop = ALU_BEQ;
          3'b001:  aluop = ALU_BNE;
          3'b100:  aluop = ALU_BLT;
          3'b101:  aluop = ALU_BGE;
          3'b110:  aluop = ALU_BLTU;
          default: aluop = ALU_BGEU;
        endcase
      end
      OPC_LOAD: begin
        cls = CL_LOAD; aluop = ALU_ADD; alusrc = 1'b1;
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        cls = CL_STORE; aluop = ALU_ADD; alusrc = 1'b1; legal = (funct3 <= 3'b010);
      end
      OPC_SYSTEM: begin
        cls = CL_CSR; legal = (funct3 == 3'b001);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      cls    = CL_NOP;
      aluop  = ALU_NONE;
      alusrc = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_fsm_multicycle : multi-cycle RV32I control FSM with csrrw-mapped GPIO |
// |   strobes. Define CTRL_TRAP_EN to trap on illegal instructions (else NOP). |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ctrl_fsm_multicycle
  import ctrl_pkg::*;
#(
  parameter int          NUM_GPIO      = 4,
  parameter logic [11:0] GPIO_CSR_BASE = 12'h7C0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                imem_valid,
  input  logic                dmem_ready,
  input  logic                branch_taken,
  output logic                imem_req,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                alusrc,
  output logic [4:0]          aluop,
  output logic                regwrite,
  output logic [2:0]          regsel,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [NUM_GPIO-1:0] gpio_we,
  output logic                trap
);

  state_e       state_q, state_d;
  instr_class_e cls_q, cls_d, dec_cls;
  aluop_e       aluop_q, aluop_d, dec_aluop;
  logic         alusrc_q, alusrc_d, dec_alusrc, dec_legal;
  logic         run_q, run_d;
  logic [31:0]  instr_q, instr_d;
  logic [4:0]   rd_q, rd_d;
  logic [11:0]  csr_q, csr_d;
  logic         unused_rs1;

  assign unused_rs1 = ^instr_q[19:15];

  ctrl_decode u_decode (
    .opcode (instr_q[6:0]),
    .funct3 (instr_q[14:12]),
    .funct7 (instr_q[31:25]),
    .cls    (dec_cls),
    .aluop  (dec_aluop),
    .alusrc (dec_alusrc),
    .legal  (dec_legal)
  );

  // run_q holds the FSM quiet for the first cycle after reset so every output reads 0 in reset
  assign run_d = 1'b1;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    cls_d    = cls_q;
    aluop_d  = aluop_q;
    alusrc_d = alusrc_q;
    rd_d     = rd_q;
    csr_d    = csr_q;
    case (state_q)
      S_FETCH: if (run_q && imem_valid) begin
        instr_d = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cls_d    = dec_cls;
        aluop_d  = dec_aluop;
        alusrc_d = dec_alusrc;
        rd_d     = instr_q[11:7];
        csr_d    = instr_q[31:20];
`ifdef CTRL_TRAP_EN
        state_d  = dec_legal ? S_EXEC : S_TRAP;
`else
        state_d  = S_EXEC;
`endif
      end
      S_EXEC:  state_d = (cls_q == CL_LOAD || cls_q == CL_STORE) ? S_MEM : S_FETCH;
      S_MEM:   if (dmem_ready) state_d = (cls_q == CL_STORE) ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      run_q    <= 1'b0;
      instr_q  <= '0;
      cls_q    <= CL_NOP;
      aluop_q  <= ALU_NONE;
      alusrc_q <= 1'b0;
      rd_q     <= '0;
      csr_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      instr_q  <= instr_d;
      cls_q    <= cls_d;
      aluop_q  <= aluop_d;
      alusrc_q <= alusrc_d;
      rd_q     <= rd_d;
      csr_q    <= csr_d;
    end
  end

  pc_sel_e pc_sel_w;
  aluop_e  aluop_w;
  regsel_e regsel_w;
  logic    csr_strobe;
  logic    rd_nz;

  assign rd_nz = (rd_q != 5'd0);

  always_comb begin
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel_w   = PCSEL_PC4;
    alusrc     = 1'b0;
    aluop_w    = ALU_NONE;
    regwrite   = 1'b0;
    regsel_w   = REGSEL_ALU;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    csr_strobe = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = run_q;
        ir_we    = run_q & imem_valid;
      end
      S_EXEC: begin
        alusrc  = alusrc_q;
        aluop_w = aluop_q;
        case (cls_q)
          CL_ALU, CL_AUIPC: begin regwrite = rd_nz; pc_we = 1'b1; end
          CL_LUI: begin regwrite = rd_nz; regsel_w = REGSEL_IMM_U; pc_we = 1'b1; end
          CL_BRANCH: begin
            pc_we    = 1'b1;
            pc_sel_w = branch_taken ? PCSEL_BRANCH : PCSEL_PC4;
          end
          CL_JAL: begin
            regwrite = rd_nz; regsel_w = REGSEL_PC4; pc_we = 1'b1; pc_sel_w = PCSEL_JAL;
          end
          CL_JALR: begin
            regwrite = rd_nz; regsel_w = REGSEL_PC4; pc_we = 1'b1; pc_sel_w = PCSEL_JALR;
          end
          CL_CSR: begin
            regwrite = rd_nz; regsel_w = REGSEL_GPIO_IN; pc_we = 1'b1; csr_strobe = 1'b1;
          end
          CL_LOAD, CL_STORE: ;
          default: pc_we = 1'b1;
        endcase
      end
      S_MEM: begin
        alusrc   = alusrc_q;
        aluop_w  = aluop_q;
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_STORE);
        pc_we    = dmem_ready & (cls_q == CL_STORE);
      end
      S_WB: begin
        regwrite = rd_nz;
        regsel_w = REGSEL_MEM;
        pc_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_sel = pc_sel_w;
  assign aluop  = aluop_w;
  assign regsel = regsel_w;

  // unsigned wrap makes addresses below the base land far out of range
  logic [11:0] csr_off;
  logic        csr_hit;
  assign csr_off = csr_q - GPIO_CSR_BASE;
  assign csr_hit = csr_strobe & (csr_off < 12'(NUM_GPIO));

  for (genvar k = 0; k < NUM_GPIO; k++) begin : g_gpio
    assign gpio_we[k] = csr_hit & (csr_off == 12'(k));
  end

`ifdef CTRL_TRAP_EN
  assign trap = (state_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ctrl_fsm_multicycle : directed bench for ctrl_fsm_multicycle            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ctrl_fsm_multicycle;
  import ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_valid, dmem_ready, branch_taken;
  logic        imem_req, ir_we, pc_we, alusrc, regwrite, dmem_req, dmem_we, trap;
  logic [1:0]  pc_sel;
  logic [4:0]  aluop;
  logic [2:0]  regsel;
  logic [3:0]  gpio_we;

  int total = 0;
  int bad   = 0;

  ctrl_fsm_multicycle #(.NUM_GPIO(4), .GPIO_CSR_BASE(12'h7C0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .imem_valid   (imem_valid),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alusrc       (alusrc),
    .aluop        (aluop),
    .regwrite     (regwrite),
    .regsel       (regsel),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .gpio_we      (gpio_we),
    .trap         (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present one instruction in FETCH; returns in EXEC (or TRAP) one time unit after the edge
  task automatic fetch_decode(input logic [31:0] w);
    instr      = w;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
  endtask

  // cycles from FETCH handshake until FETCH is re-entered, with dmem_ready after `waits` cycles
  task automatic measure(input logic [31:0] w, input int waits, output int n);
    int mw;
    n  = 0;
    mw = 0;
    instr      = w;
    imem_valid = 1'b1;
    tick();
    n++;
    imem_valid = 1'b0;
    while (imem_req !== 1'b1 && n < 20) begin
      if (dmem_req === 1'b1) begin
        dmem_ready = (mw == waits);
        mw++;
      end else begin
        dmem_ready = 1'b0;
      end
      tick();
      dmem_ready = 1'b0;
      n++;
    end
  endtask

  int n;
  logic [11:0] csr_tab [5] = '{12'h7C2, 12'h7C4, 12'h7C0, 12'h7C3, 12'h7BF};
  logic [3:0]  gpio_tab[5] = '{4'b0100, 4'b0000, 4'b0001, 4'b1000, 4'b0000};

  initial begin
    rst_n = 1'b0; instr = '0; imem_valid = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    #2;
    chk("rst_outputs", 32'({imem_req, ir_we, pc_we, pc_sel, alusrc, aluop, regwrite,
                            regsel, dmem_req, dmem_we, gpio_we, trap}), 32'd0);
    tick(); tick();
    chk("rst_held_imem_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("boot_imem_req", 32'(imem_req), 32'd1);

    // instruction memory wait states: request held, no IR write
    tick(); #1;
    chk("fetch_wait_imem_req", 32'(imem_req), 32'd1);
    chk("fetch_wait_ir_we", 32'(ir_we), 32'd0);

    // addi x5,x0,7
    instr = 32'h00700293; imem_valid = 1'b1; #1;
    chk("addi_ir_we", 32'(ir_we), 32'd1);
    tick(); imem_valid = 1'b0; #1;
    chk("addi_decode_quiet", 32'({imem_req, ir_we, pc_we, regwrite}), 32'd0);
    tick(); #1;
    chk("addi_aluop", 32'(aluop), 32'(ALU_ADD));
    chk("addi_alusrc", 32'(alusrc), 32'd1);
    chk("addi_regwrite", 32'(regwrite), 32'd1);
    chk("addi_pc_we", 32'(pc_we), 32'd1);
    chk("addi_pc_sel", 32'(pc_sel), 32'(PCSEL_PC4));
    chk("addi_regsel", 32'(regsel), 32'(REGSEL_ALU));
    tick(); #1;
    chk("addi_back_fetch", 32'({imem_req, pc_we}), 32'b10);

    // addi x0,x0,7
    fetch_decode(32'h00700013); #1;
    chk("addi_x0_regwrite", 32'(regwrite), 32'd0);
    chk("addi_x0_pc_we", 32'(pc_we), 32'd1);
    tick();

    // csrrw x1,csr,x2 across the GPIO window and its edges
    for (int i = 0; i < 5; i++) begin
      fetch_decode({csr_tab[i], 5'd2, 3'b001, 5'd1, 7'h73}); #1;
      chk($sformatf("csr_%h_gpio_we", csr_tab[i]), 32'(gpio_we), 32'(gpio_tab[i]));
      chk($sformatf("csr_%h_regsel", csr_tab[i]), 32'(regsel), 32'(REGSEL_GPIO_IN));
      chk($sformatf("csr_%h_regwrite", csr_tab[i]), 32'(regwrite), 32'd1);
      tick(); #1;
      chk($sformatf("csr_%h_gpio_after", csr_tab[i]), 32'(gpio_we), 32'd0);
    end

    // lw x3,0(x4) with three dmem wait cycles
    fetch_decode(32'h00022183); #1;
    chk("lw_exec_alusrc", 32'(alusrc), 32'd1);
    chk("lw_exec_no_strobe", 32'({pc_we, regwrite}), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3); #1;
      chk($sformatf("lw_mem%0d_req_we", i), 32'({dmem_req, dmem_we, pc_we}), 32'b100);
      tick();
    end
    dmem_ready = 1'b0; #1;
    chk("lw_wb_regsel", 32'(regsel), 32'(REGSEL_MEM));
    chk("lw_wb_strobes", 32'({regwrite, pc_we, dmem_req}), 32'b110);
    chk("lw_wb_pc_sel", 32'(pc_sel), 32'(PCSEL_PC4));
    tick(); #1;
    chk("lw_back_fetch", 32'(imem_req), 32'd1);

    // sw x2,0(x4), zero-wait
    fetch_decode(32'h00222023);
    tick();
    dmem_ready = 1'b1; #1;
    chk("sw_mem", 32'({dmem_req, dmem_we, pc_we}), 32'b111);
    tick(); dmem_ready = 1'b0; #1;
    chk("sw_back_fetch", 32'({imem_req, dmem_req}), 32'b10);

    // beq: pc_sel follows branch_taken combinationally in EXEC
    fetch_decode(32'h00000463);
    branch_taken = 1'b1; #1;
    chk("beq_taken_pc_sel", 32'(pc_sel), 32'(PCSEL_BRANCH));
    chk("beq_taken_pc_we", 32'({pc_we, regwrite}), 32'b10);
    branch_taken = 1'b0; #1;
    chk("beq_not_taken_pc_sel", 32'(pc_sel), 32'(PCSEL_PC4));
    tick();

    // jal x1
    fetch_decode(32'h000000EF); #1;
    chk("jal_sel", 32'({pc_sel, regsel}), 32'({PCSEL_JAL, REGSEL_PC4}));
    chk("jal_strobes", 32'({pc_we, regwrite}), 32'b11);
    tick();

    // stray handshakes outside their states
    dmem_ready = 1'b1; branch_taken = 1'b1;
    tick(); #1;
    chk("ignored_inputs", 32'({imem_req, dmem_req, pc_we}), 32'b100);
    dmem_ready = 1'b0; branch_taken = 1'b0;

    // end-to-end latencies
    measure(32'h00700293, 0, n); chk("lat_addi", 32'(n), 32'd3);
    measure(32'h7C2110F3, 0, n); chk("lat_csr", 32'(n), 32'd3);
    measure(32'h00222023, 0, n); chk("lat_sw", 32'(n), 32'd4);
    measure(32'h00022183, 0, n); chk("lat_lw", 32'(n), 32'd5);
    measure(32'h00022183, 3, n); chk("lat_lw_3wait", 32'(n), 32'd8);

    // asynchronous reset in the middle of a data access
    fetch_decode(32'h00022183);
    tick(); #1;
    chk("midmem_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0; #1;
    chk("midmem_req_dropped", 32'(dmem_req), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); #1;
    chk("midmem_fetch_after", 32'({imem_req, dmem_req}), 32'b10);

    // illegal instruction
    fetch_decode(32'hFFFFFFFF); #1;
`ifdef CTRL_TRAP_EN
    chk("illegal_trap", 32'(trap), 32'd1);
    chk("illegal_no_strobe", 32'({pc_we, regwrite, ir_we}), 32'd0);
    tick(); tick(); tick(); #1;
    chk("illegal_trap_held", 32'({trap, imem_req, pc_we}), 32'b100);
`else
    chk("illegal_nop_pc", 32'({pc_we, pc_sel}), 32'({1'b1, PCSEL_PC4}));
    chk("illegal_nop_quiet", 32'({regwrite, trap, gpio_we}), 32'd0);
    tick(); #1;
    chk("illegal_nop_fetch", 32'(imem_req), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
